typec_tx_pkt: RTL

Parametrised next-generation TYPEC packet transmitter. It serialises one handshake, status or data packet per request onto the byte-wide link, with a valid strobe on every byte. Packet fields are captured when the request is accepted. RAM read latency, address/length widths and sync-preamble length are parameters. CRCs are computed internally and a request can be aborted. It sits between the packet scheduler (fs/fd handshake, payload RAM) and the PHY byte serialiser.

---
 rtl/typec_tx_pkt.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/typec_tx_pkt.sv
// TYPEC packet transmitter: serialises one handshake, status or data packet per
// fs/fd request onto a byte link, generating CRC5/CRC16 internally.
module typec_tx_pkt #(
  parameter int ADDR_W   = 12,
  parameter int LEN_W    = 12,
  parameter int RAM_LAT  = 2,
  parameter int SYNC_NUM = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fs_i,
  output logic              fd_o,
  input  logic              abort_i,
  input  logic [3:0]        btype_i,
  input  logic [ADDR_W-1:0] ram_addr_init_i,
  input  logic [LEN_W-1:0]  data_len_i,
  input  logic [3:0]        didx_i,
  input  logic [7:0]        type_i,
  input  logic [7:0]        temp_i,
  input  logic [7:0]        head_i,
  output logic [ADDR_W-1:0] ram_rxa_o,
  input  logic [7:0]        ram_rxd_i,
  output logic [7:0]        com_txd_o,
  output logic              com_txv_o
);

  localparam logic [3:0] BT_ACK   = 4'h1;
  localparam logic [3:0] BT_NAK   = 4'h2;
  localparam logic [3:0] BT_STALL = 4'h3;
  localparam logic [3:0] BT_DLINK = 4'h8;
  localparam logic [3:0] BT_DTYPE = 4'h9;
  localparam logic [3:0] BT_DTEMP = 4'hA;
  localparam logic [3:0] BT_DATA0 = 4'hD;
  localparam logic [3:0] BT_DATA1 = 4'hE;

  typedef enum logic [3:0] {
    S_IDLE, S_WAIT, S_SYNC, S_PID, S_LEN0, S_LEN1, S_STAT0, S_STAT1,
    S_CRC5, S_HEAD0, S_HEAD1, S_DATA, S_CRC16H, S_CRC16L, S_DONE
  } state_t;

  typedef struct packed {
    logic [3:0]       btype;
    logic [LEN_W-1:0] len;
    logic [3:0]       didx;
    logic [7:0]       typ;
    logic [7:0]       temp;
    logic [7:0]       head;
  } req_t;

  state_t            state_q, state_d;
  req_t              req_q, req_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [ADDR_W-1:0] rxa_q, rxa_d;
  logic [4:0]        crc5_q, crc5_d;
  logic [15:0]       crc16_q, crc16_d;
  logic [7:0]        txd_q, byte_d;
  logic              txv_q, vld_d;
  logic [15:0]       len16;
  logic              is_stat, is_data, crc_en, fetch;

  function automatic logic [4:0] crc5_upd(input logic [4:0] crc, input logic [7:0] d);
    logic [4:0] c;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      if (c[4] ^ d[i]) c = {c[3:0], 1'b0} ^ 5'h05;
      else             c = {c[3:0], 1'b0};
    end
    return c;
  endfunction

  function automatic logic [15:0] crc16_upd(input logic [15:0] crc, input logic [7:0] d);
    logic [15:0] c;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      if (c[15] ^ d[i]) c = {c[14:0], 1'b0} ^ 16'h8005;
      else              c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

  assign cnt_inc = cnt_q + 1'b1;
  assign is_stat = req_q.btype inside {BT_DLINK, BT_DTYPE, BT_DTEMP};
  assign is_data = req_q.btype inside {BT_DATA0, BT_DATA1};
  assign len16   = 16'(req_q.len) + 16'd2;

  // Payload address k must lead DATA cycle k by RAM_LAT, so the address walk
  // begins RAM_LAT states ahead of the first DATA state.
  assign fetch = is_data && ((state_q == S_DATA) || (state_q == S_HEAD1) ||
                             (state_q == S_HEAD0 && RAM_LAT >= 2) ||
                             (state_q == S_LEN1  && RAM_LAT >= 3) ||
                             (state_q == S_LEN0  && RAM_LAT >= 4));

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    cnt_d   = cnt_q;
    rxa_d   = rxa_q;
    crc5_d  = crc5_q;
    crc16_d = crc16_q;
    byte_d  = 8'h00;
    vld_d   = 1'b0;
    crc_en  = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_WAIT;
      S_WAIT: begin
        if (fs_i) begin
          state_d     = S_SYNC;
          cnt_d       = '0;
          rxa_d       = ram_addr_init_i;
          req_d.btype = btype_i;
          req_d.len   = data_len_i;
          req_d.didx  = didx_i;
          req_d.typ   = type_i;
          req_d.temp  = temp_i;
          req_d.head  = head_i;
        end
      end
      S_SYNC: begin
        byte_d = 8'h0F;
        vld_d  = 1'b1;
        cnt_d  = cnt_inc;
        if (cnt_q == LEN_W'(SYNC_NUM - 1)) state_d = S_PID;
      end
      S_PID: begin
        crc5_d  = 5'h1F;
        crc16_d = 16'hFFFF;
        vld_d   = 1'b1;
        state_d = (is_stat || is_data) ? S_LEN0 : S_DONE;
        case (req_q.btype)
          BT_ACK:                       byte_d = 8'h2D;
          BT_NAK:                       byte_d = 8'hA5;
          BT_STALL:                     byte_d = 8'hE1;
          BT_DLINK, BT_DTYPE, BT_DTEMP: byte_d = 8'hD2;
          BT_DATA0:                     byte_d = 8'h96;
          BT_DATA1:                     byte_d = 8'h5A;
          default:                      vld_d  = 1'b0;
        endcase
      end
      S_LEN0: begin
        byte_d  = is_stat ? 8'h00 : len16[15:8];
        vld_d   = 1'b1;
        state_d = S_LEN1;
      end
      S_LEN1: begin
        byte_d  = is_stat ? 8'h02 : len16[7:0];
        vld_d   = 1'b1;
        state_d = is_stat ? S_STAT0 : S_HEAD0;
      end
      S_STAT0: begin
        crc_en  = 1'b1;
        vld_d   = 1'b1;
        state_d = S_STAT1;
        case (req_q.btype)
          BT_DLINK: byte_d = 8'hD1;
          BT_DTYPE: byte_d = {4'h1, req_q.didx};
          default:  byte_d = {4'h9, req_q.didx};
        endcase
      end
      S_STAT1: begin
        crc_en  = 1'b1;
        vld_d   = 1'b1;
        state_d = S_CRC5;
        case (req_q.btype)
          BT_DLINK: byte_d = 8'h23;
          BT_DTYPE: byte_d = req_q.typ;
          default:  byte_d = req_q.temp;
        endcase
      end
      S_CRC5: begin
        byte_d  = {3'b000, crc5_q};
        vld_d   = 1'b1;
        state_d = S_DONE;
      end
      S_HEAD0: begin
        crc_en  = 1'b1;
        vld_d   = 1'b1;
        byte_d  = {4'h3, req_q.didx};
        state_d = S_HEAD1;
      end
      S_HEAD1: begin
        crc_en  = 1'b1;
        vld_d   = 1'b1;
        byte_d  = req_q.head;
        cnt_d   = '0;
        state_d = (req_q.len == '0) ? S_CRC16H : S_DATA;
      end
      S_DATA: begin
        crc_en = 1'b1;
        vld_d  = 1'b1;
        byte_d = ram_rxd_i;
        cnt_d  = cnt_inc;
        if (cnt_inc == req_q.len) state_d = S_CRC16H;
      end
      S_CRC16H: begin
        byte_d  = crc16_q[15:8];
        vld_d   = 1'b1;
        state_d = S_CRC16L;
      end
      S_CRC16L: begin
        byte_d  = crc16_q[7:0];
        vld_d   = 1'b1;
        state_d = S_DONE;
      end
      S_DONE:  if (!fs_i) state_d = S_WAIT;
      default: state_d = S_IDLE;
    endcase

    if (crc_en) begin
      crc5_d  = crc5_upd(crc5_q, byte_d);
      crc16_d = crc16_upd(crc16_q, byte_d);
    end
    if (fetch) rxa_d = rxa_q + 1'b1;
    if (abort_i && state_q != S_IDLE && state_q != S_WAIT) begin
      state_d = S_WAIT;
      vld_d   = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      req_q   <= '0;
      cnt_q   <= '0;
      rxa_q   <= '0;
      crc5_q  <= 5'h1F;
      crc16_q <= 16'hFFFF;
      txd_q   <= 8'h00;
      txv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
      rxa_q   <= rxa_d;
      crc5_q  <= crc5_d;
      crc16_q <= crc16_d;
      txd_q   <= byte_d;
      txv_q   <= vld_d;
    end
  end

  assign fd_o      = (state_q == S_DONE);
  assign ram_rxa_o = rxa_q;
  assign com_txd_o = txd_q;
  assign com_txv_o = txv_q;

endmodule
